// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch engine.
// Holds the FSM state encoding, the queue entry layout and the bundle
// geometry used by both the engine and its instruction queue.
package fetch_pkg;

  localparam int INSTR_W          = 32;
  localparam int BUNDLE_W         = 128;
  localparam int WORDS_PER_BUNDLE = 4;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    ABORT = 1'b1
  } fetch_state_t;

  // One queued instruction together with the word index it was fetched from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

  // Builds the queue entry for word k of a bundle fetched at word index base.
  function automatic fetch_entry_t bundle_word(
    input logic [BUNDLE_W-1:0] bundle,
    input logic [31:0]         base,
    input int                  k
  );
    fetch_entry_t e;
    e.instr = bundle[k*INSTR_W +: INSTR_W];
    e.pc    = base + 32'(k);
    return e;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Instruction queue: circular buffer of fetch entries accepting a whole
// four-word bundle per push and releasing one entry per pop.
// The caller guarantees room for four entries before pushing; pops on an
// empty queue are ignored. clr empties the queue on the next edge.
module instr_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 16
)
(
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clr,
  input  logic                                  push,
  input  fetch_entry_t [WORDS_PER_BUNDLE-1:0]   push_data,
  input  logic                                  pop,
  output fetch_entry_t                          head,
  output logic [$clog2(DEPTH):0]                count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   PUSH_INC = (AW+1)'(WORDS_PER_BUNDLE);
  localparam logic [AW-1:0] PTR_STEP = AW'(WORDS_PER_BUNDLE);

  fetch_entry_t     mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_next;
  logic             pop_ok;

  assign pop_ok = pop && (count != '0);
  assign head   = mem[rd_ptr];

  // Storage write: the four bundle words land in consecutive slots.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < WORDS_PER_BUNDLE; k++) begin
        mem[wr_ptr + AW'(k)] <= push_data[k];
      end
    end
  end

  // Occupancy after this cycle's push and pop.
  always_comb begin
    count_next = count;
    if (push) begin
      count_next = count_next + PUSH_INC;
    end
    if (pop_ok) begin
      count_next = count_next - (AW+1)'(1);
    end
  end

  // Pointers and occupancy; clear and reset both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_STEP;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_next;
    end
  end

endmodule

// File: rtl/fetch_engine.sv
// Fetch-side initiator for the instruction cache. Requests four-word
// bundles at a word-indexed PC, unpacks them into the instruction queue
// and hands instructions to decode one per cycle. A redirect aborts the
// outstanding request, flushes the queue and restarts at the new PC.
//
// Optional build macro FETCH_PERF_CNT_EN adds saturating counters of
// accepted bundles and of fetch stall cycles (FETCH with rd_en low).
//
// state | meaning
// ------+-------------------------------------------------------------
// FETCH | requesting bundles at pc whenever the queue has room for four
// ABORT | one-cycle abort pulse after a redirect; queue already empty
module fetch_engine
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
  input  logic                   clk,
  input  logic                   rst,
  output logic [31:0]            pc_in,
  output logic                   rd_en,
  output logic                   abort,
  input  logic [BUNDLE_W-1:0]    Dout,
  input  logic                   Dout_valid,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic [INSTR_W-1:0]     instr_out,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [31:0]            instr_pc,
  output logic [$clog2(DEPTH):0] count
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            perf_bundles,
  output logic [31:0]            perf_stalls
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] ROOM_LIMIT = CW'(DEPTH - WORDS_PER_BUNDLE);

  fetch_state_t                          state;
  fetch_state_t                          state_next;
  logic [31:0]                           pc;
  logic [31:0]                           pc_next;
  logic                                  has_room;
  logic                                  accept;
  logic                                  pop;
  fetch_entry_t [WORDS_PER_BUNDLE-1:0]   push_data;
  fetch_entry_t                          head;

  // Requests only go out with room for a full bundle. rd_en is also held
  // low while rst is asserted so nothing is requested in the reset cycle.
  assign has_room = (count <= ROOM_LIMIT);
  assign rd_en    = (state == FETCH) && has_room && !rst;
  assign abort    = (state == ABORT);
  assign pc_in    = pc;

  // A redirect cycle discards any response and any pop; the queue is
  // cleared on the same edge.
  assign accept = rd_en && Dout_valid && !redirect_valid;
  assign pop    = instr_valid && instr_ready && !redirect_valid;

  assign instr_valid = (count != '0);
  assign instr_out   = head.instr;
  assign instr_pc    = head.pc;

  // Unpack the bundle into four tagged queue entries.
  always_comb begin
    push_data = '0;
    for (int k = 0; k < WORDS_PER_BUNDLE; k++) begin
      push_data[k] = bundle_word(Dout, pc, k);
    end
  end

  // Next state and next PC; a redirect overrides everything else.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    if (redirect_valid) begin
      state_next = ABORT;
      pc_next    = redirect_pc;
    end else begin
      if (state == ABORT) begin
        state_next = FETCH;
      end
      if (accept) begin
        pc_next = pc + 32'(WORDS_PER_BUNDLE);
      end
    end
  end

  // State and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  instr_fifo #(
    .DEPTH (DEPTH)
  ) u_instr_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (redirect_valid),
    .push      (accept),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

`ifdef FETCH_PERF_CNT_EN
  logic stall;

  assign stall = (state == FETCH) && !has_room;

  // Saturating performance counters; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bundles <= '0;
      perf_stalls  <= '0;
    end else begin
      if (accept && (perf_bundles != 32'hFFFF_FFFF)) begin
        perf_bundles <= perf_bundles + 32'd1;
      end
      if (stall && (perf_stalls != 32'hFFFF_FFFF)) begin
        perf_stalls <= perf_stalls + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_engine.sv
// Directed self-checking bench for fetch_engine (DEPTH=16, RESET_PC=0x10).
// Inputs change 1ns after the rising edge; outputs are sampled on the
// falling edge. The cache responder is either zero-latency (answers
// whatever pc_in is asking for) or driven by hand per test.
module tb_fetch_engine;

  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  pc_in;
  logic         rd_en;
  logic         abort;
  logic [127:0] Dout;
  logic         Dout_valid;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic [31:0]  instr_out;
  logic         instr_valid;
  logic         instr_ready;
  logic [31:0]  instr_pc;
  logic [4:0]   count;

  logic         resp_zero;
  logic         man_valid;
  logic [127:0] man_dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [127:0] bundle(input logic [31:0] a);
    return {w(a + 32'd3), w(a + 32'd2), w(a + 32'd1), w(a)};
  endfunction

  assign Dout_valid = resp_zero ? rd_en : man_valid;
  assign Dout       = resp_zero ? bundle(pc_in) : man_dout;

  fetch_engine #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0010)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .rd_en          (rd_en),
    .abort          (abort),
    .Dout           (Dout),
    .Dout_valid     (Dout_valid),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_out      (instr_out),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_pc       (instr_pc),
    .count          (count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    int n;
    repeat (2) tick();
    @(negedge clk);
    total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b exp=0", rd_en); end
    total++; if (abort !== 1'b0) begin bad++; $display("FAIL reset_abort got=%b exp=0", abort); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_instr_valid got=%b exp=0", instr_valid); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++; if (rd_en !== 1'b1) begin bad++; $display("FAIL first_rd_en got=%b exp=1", rd_en); end
    total++; if (pc_in !== 32'h10) begin bad++; $display("FAIL first_pc_in got=%h exp=00000010", pc_in); end
    exp_pc = 32'h10;
    n = 0;
    for (int i = 0; i < 20 && n < 8; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        total++; if (instr_pc !== exp_pc) begin bad++; $display("FAIL seq_pc got=%h exp=%h", instr_pc, exp_pc); end
        total++; if (instr_out !== w(exp_pc)) begin bad++; $display("FAIL seq_instr got=%h exp=%h", instr_out, w(exp_pc)); end
        exp_pc = exp_pc + 32'd1;
        n++;
      end
    end
    total++; if (n != 8) begin bad++; $display("FAIL seq_count got=%0d exp=8", n); end
  endtask

  task automatic test_full();
    int n;
    tick();
    resp_zero      = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    redirect_valid = 1'b0;
    resp_zero      = 1'b1;
    @(negedge clk);
    total++; if (abort !== 1'b1) begin bad++; $display("FAIL full_setup_abort got=%b exp=1", abort); end
    tick();
    @(negedge clk);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (rd_en) begin
        total++; if (pc_in !== 32'(4 * n)) begin bad++; $display("FAIL full_req_pc got=%h exp=%h", pc_in, 32'(4 * n)); end
        n++;
      end
      tick();
      @(negedge clk);
    end
    total++; if (n != 4) begin bad++; $display("FAIL full_accepts got=%0d exp=4", n); end
    total++; if (count !== 5'd16) begin bad++; $display("FAIL full_count got=%0d exp=16", count); end
    total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL full_rd_en got=%b exp=0", rd_en); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL full_head got=%h exp=00000000", instr_pc); end
    tick();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    @(negedge clk);
    total++; if (count !== 5'd15) begin bad++; $display("FAIL pop1_count got=%0d exp=15", count); end
    total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL pop1_rd_en got=%b exp=0", rd_en); end
    total++; if (instr_pc !== 32'h1) begin bad++; $display("FAIL pop1_head got=%h exp=00000001", instr_pc); end
    instr_ready = 1'b1;
    tick(); tick(); tick();
    instr_ready = 1'b0;
    resp_zero   = 1'b0;
    man_valid   = 1'b0;
    @(negedge clk);
    total++; if (count !== 5'd12) begin bad++; $display("FAIL pop4_count got=%0d exp=12", count); end
    total++; if (rd_en !== 1'b1) begin bad++; $display("FAIL pop4_rd_en got=%b exp=1", rd_en); end
    total++; if (pc_in !== 32'h10) begin bad++; $display("FAIL pop4_pc_in got=%h exp=00000010", pc_in); end
    total++; if (instr_pc !== 32'h4) begin bad++; $display("FAIL pop4_head got=%h exp=00000004", instr_pc); end
  endtask

  task automatic test_latency();
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      total++; if (rd_en !== 1'b1) begin bad++; $display("FAIL wait_rd_en got=%b exp=1", rd_en); end
      total++; if (pc_in !== 32'h10) begin bad++; $display("FAIL wait_pc_in got=%h exp=00000010", pc_in); end
      total++; if (count !== 5'd12) begin bad++; $display("FAIL wait_count got=%0d exp=12", count); end
    end
    tick();
    man_dout  = bundle(32'h10);
    man_valid = 1'b1;
    tick();
    man_valid = 1'b0;
    @(negedge clk);
    total++; if (count !== 5'd16) begin bad++; $display("FAIL late_count got=%0d exp=16", count); end
    total++; if (pc_in !== 32'h14) begin bad++; $display("FAIL late_pc_in got=%h exp=00000014", pc_in); end
    total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL late_rd_en got=%b exp=0", rd_en); end
  endtask

  task automatic test_redirect();
    tick();
    instr_ready = 1'b1;
    repeat (9) tick();
    instr_ready = 1'b0;
    @(negedge clk);
    total++; if (count !== 5'd7) begin bad++; $display("FAIL pre_redir_count got=%0d exp=7", count); end
    total++; if (rd_en !== 1'b1) begin bad++; $display("FAIL pre_redir_rd_en got=%b exp=1", rd_en); end
    total++; if (instr_pc !== 32'hD) begin bad++; $display("FAIL pre_redir_head got=%h exp=0000000d", instr_pc); end
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    man_dout       = bundle(32'h14);
    man_valid      = 1'b1;
    instr_ready    = 1'b1;
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    @(negedge clk);
    total++; if (abort !== 1'b1) begin bad++; $display("FAIL redir_abort got=%b exp=1", abort); end
    total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL redir_rd_en got=%b exp=0", rd_en); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL redir_count got=%0d exp=0", count); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL redir_valid got=%b exp=0", instr_valid); end
    tick();
    man_valid = 1'b0;
    @(negedge clk);
    total++; if (abort !== 1'b0) begin bad++; $display("FAIL redir2_abort got=%b exp=0", abort); end
    total++; if (rd_en !== 1'b1) begin bad++; $display("FAIL redir2_rd_en got=%b exp=1", rd_en); end
    total++; if (pc_in !== 32'h200) begin bad++; $display("FAIL redir2_pc_in got=%h exp=00000200", pc_in); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL redir2_count got=%0d exp=0", count); end
    tick();
    man_dout  = bundle(32'h200);
    man_valid = 1'b1;
    tick();
    man_valid = 1'b0;
    @(negedge clk);
    total++; if (count !== 5'd4) begin bad++; $display("FAIL redir3_count got=%0d exp=4", count); end
    total++; if (instr_pc !== 32'h200) begin bad++; $display("FAIL redir3_head got=%h exp=00000200", instr_pc); end
    total++; if (instr_out !== w(32'h200)) begin bad++; $display("FAIL redir3_instr got=%h exp=%h", instr_out, w(32'h200)); end
  endtask

  task automatic test_push_pop();
    tick();
    man_dout  = bundle(32'h204);
    man_valid = 1'b1;
    tick();
    man_valid   = 1'b0;
    instr_ready = 1'b1;
    tick(); tick(); tick();
    man_dout  = bundle(32'h208);
    man_valid = 1'b1;
    @(negedge clk);
    total++; if (count !== 5'd5) begin bad++; $display("FAIL pp_pre_count got=%0d exp=5", count); end
    total++; if (instr_pc !== 32'h203) begin bad++; $display("FAIL pp_pre_head got=%h exp=00000203", instr_pc); end
    total++; if (pc_in !== 32'h208) begin bad++; $display("FAIL pp_pre_pc_in got=%h exp=00000208", pc_in); end
    tick();
    man_valid   = 1'b0;
    instr_ready = 1'b0;
    @(negedge clk);
    total++; if (count !== 5'd8) begin bad++; $display("FAIL pp_count got=%0d exp=8", count); end
    total++; if (instr_pc !== 32'h204) begin bad++; $display("FAIL pp_head got=%h exp=00000204", instr_pc); end
    total++; if (instr_out !== w(32'h204)) begin bad++; $display("FAIL pp_instr got=%h exp=%h", instr_out, w(32'h204)); end
    total++; if (pc_in !== 32'h20C) begin bad++; $display("FAIL pp_pc_in got=%h exp=0000020c", pc_in); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    man_dout  = bundle(32'hFFFF_FFFC);
    man_valid = 1'b1;
    tick();
    man_valid = 1'b0;
    @(negedge clk);
    total++; if (pc_in !== 32'h0) begin bad++; $display("FAIL wrap_pc_in got=%h exp=00000000", pc_in); end
    total++; if (count !== 5'd4) begin bad++; $display("FAIL wrap_count got=%0d exp=4", count); end
    tick();
    instr_ready = 1'b1;
    exp_pc = 32'hFFFF_FFFC;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (instr_pc !== exp_pc) begin bad++; $display("FAIL wrap_tag got=%h exp=%h", instr_pc, exp_pc); end
      total++; if (instr_out !== w(exp_pc)) begin bad++; $display("FAIL wrap_instr got=%h exp=%h", instr_out, w(exp_pc)); end
      exp_pc = exp_pc + 32'd1;
      tick();
    end
    instr_ready = 1'b0;
    @(negedge clk);
    total++; if (count !== 5'd0) begin bad++; $display("FAIL wrap_drain got=%0d exp=0", count); end
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    tick();
    man_dout  = bundle(32'hFFFF_FFFE);
    man_valid = 1'b1;
    tick();
    man_valid = 1'b0;
    @(negedge clk);
    total++; if (pc_in !== 32'h2) begin bad++; $display("FAIL odd_pc_in got=%h exp=00000002", pc_in); end
    total++; if (instr_pc !== 32'hFFFF_FFFE) begin bad++; $display("FAIL odd_head got=%h exp=fffffffe", instr_pc); end
    total++; if (count !== 5'd4) begin bad++; $display("FAIL odd_count got=%0d exp=4", count); end
  endtask

  task automatic test_reset_mid();
    tick();
    rst = 1'b1;
    @(negedge clk);
    total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL mid_rst_rd_en got=%b exp=0", rd_en); end
    tick();
    rst         = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    total++; if (count !== 5'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", count); end
    total++; if (pc_in !== 32'h10) begin bad++; $display("FAIL mid_pc_in got=%h exp=00000010", pc_in); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", instr_valid); end
    total++; if (rd_en !== 1'b1) begin bad++; $display("FAIL mid_rd_en got=%b exp=1", rd_en); end
    tick();
    @(negedge clk);
    total++; if (count !== 5'd0) begin bad++; $display("FAIL empty_pop got=%0d exp=0", count); end
    instr_ready = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    resp_zero      = 1'b1;
    man_valid      = 1'b0;
    man_dout       = '0;
    test_reset();
    test_full();
    test_latency();
    test_redirect();
    test_push_pop();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
